// File: rtl/stream_seq_checker_pkg.sv
// Shared types and constants for the stream sequence checker: FSM states,
// backpressure modes and the LFSR seed.
package stream_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_ALWAYS    = 2'b00,
        MODE_ALTERNATE = 2'b01,
        MODE_LFSR      = 2'b10,
        MODE_NEVER     = 2'b11
    } mode_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/stream_seq_checker_if.sv
// Valid/ready stream carrying the checked data; master is the producer,
// slave is the checker.
interface stream_seq_checker_if #(
    parameter int width_p = 32
) ();
    logic               valid_i;
    logic [width_p-1:0] data_i;
    logic               ready_o;

    modport master (output valid_i, output data_i, input ready_o);
    modport slave  (input valid_i, input data_i, output ready_o);
endinterface

// File: rtl/stream_seq_checker_lfsr.sv
// 16-bit maximal-length Fibonacci LFSR (x^16 + x^14 + x^13 + x^11 + 1),
// reloadable to the package seed.
module lfsr16
    import stream_seq_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        load_i,
    input  logic        en_i,
    output logic [15:0] q_o
);

    logic [15:0] q_reg;
    logic [15:0] q_next;

    assign q_next[15] = q_reg[0] ^ q_reg[2] ^ q_reg[3] ^ q_reg[5];

    for (genvar gi = 0; gi < 15; gi++) begin : g_shift
        assign q_next[gi] = q_reg[gi+1];
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            q_reg <= LFSR_SEED;
        end else if (load_i) begin
            q_reg <= LFSR_SEED;
        end else if (en_i) begin
            q_reg <= q_next;
        end
    end

    assign q_o = q_reg;

endmodule

// File: rtl/stream_seq_checker.sv
// Checks that a valid/ready stream carries 0,1,2,... for count_p beats under a
// selectable backpressure pattern. Define STREAM_SEQ_CHECKER_TIMEOUT_EN to add a stall timeout.
module stream_seq_checker
    import stream_seq_pkg::*;
#(
    parameter int width_p   = 32,
    parameter int count_p   = 256,
    parameter int timeout_p = 1024
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic                start_i,
    input  logic [1:0]          mode_i,
    stream_seq_checker_if.slave stream,
    output logic                done_o,
    output logic                pass_o,
    output logic                error_o,
    output logic [15:0]         err_count_o,
    output logic [15:0]         first_err_idx_o,
    output logic [15:0]         beat_count_o,
    output logic                timeout_o
);

    state_t             state_reg;
    mode_t              mode_reg;
    logic               phase_reg;
    logic [width_p-1:0] expected_reg;
    logic [15:0]        beat_count_reg;
    logic [15:0]        err_count_reg;
    logic [15:0]        first_err_idx_reg;
    logic               done_reg;
    logic               pass_reg;
    logic               error_reg;

    logic               start_ok;
    logic               ready;
    logic               beat;
    logic               mismatch;
    logic               last_beat;
    logic               timeout_hit;
    logic [15:0]        err_count_next;
    logic [15:0]        lfsr_q;
    logic               lfsr_unused;

    assign start_ok = start_i && (state_reg != RUN);

    lfsr16 u_lfsr (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .load_i   (start_ok),
        .en_i     (state_reg == RUN),
        .q_o      (lfsr_q)
    );

    assign lfsr_unused = ^lfsr_q[15:1];

    // ready depends only on registers, so it never loops back through valid/data
    always_comb begin
        ready = 1'b0;
        if (state_reg == RUN) begin
            case (mode_reg)
                MODE_ALWAYS:    ready = 1'b1;
                MODE_ALTERNATE: ready = phase_reg;
                MODE_LFSR:      ready = lfsr_q[0];
                MODE_NEVER:     ready = 1'b0;
                default:        ready = 1'b0;
            endcase
        end
    end

    assign beat           = stream.valid_i && ready;
    assign mismatch       = beat && (stream.data_i != expected_reg);
    assign last_beat      = beat && (beat_count_reg == 16'(count_p - 1));
    assign err_count_next = (mismatch && (err_count_reg != 16'hFFFF))
                          ? err_count_reg + 16'd1 : err_count_reg;

`ifdef STREAM_SEQ_CHECKER_TIMEOUT_EN
    localparam int stall_w = $clog2(timeout_p + 1);

    logic [stall_w-1:0] stall_reg;
    logic               timeout_reg;

    assign timeout_hit = (state_reg == RUN) && !beat
                      && (stall_reg == stall_w'(timeout_p - 1));

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            stall_reg   <= '0;
            timeout_reg <= 1'b0;
        end else if (start_ok) begin
            stall_reg   <= '0;
            timeout_reg <= 1'b0;
        end else if (state_reg == RUN) begin
            if (beat) begin
                stall_reg <= '0;
            end else if (timeout_hit) begin
                timeout_reg <= 1'b1;
            end else begin
                stall_reg <= stall_reg + 1'b1;
            end
        end
    end

    assign timeout_o = timeout_reg;
`else
    logic timeout_unused;

    assign timeout_unused = (timeout_p > 0);
    assign timeout_hit    = 1'b0;
    assign timeout_o      = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_reg         <= IDLE;
            mode_reg          <= MODE_ALWAYS;
            phase_reg         <= 1'b0;
            expected_reg      <= '0;
            beat_count_reg    <= '0;
            err_count_reg     <= '0;
            first_err_idx_reg <= '0;
            done_reg          <= 1'b0;
            pass_reg          <= 1'b0;
            error_reg         <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_reg         <= RUN;
                        mode_reg          <= mode_t'(mode_i);
                        phase_reg         <= 1'b0;
                        expected_reg      <= '0;
                        beat_count_reg    <= '0;
                        err_count_reg     <= '0;
                        first_err_idx_reg <= '0;
                        done_reg          <= 1'b0;
                        pass_reg          <= 1'b0;
                        error_reg         <= 1'b0;
                    end
                end
                RUN: begin
                    phase_reg <= ~phase_reg;
                    if (beat) begin
                        expected_reg   <= expected_reg + 1'b1;
                        beat_count_reg <= beat_count_reg + 16'd1;
                        err_count_reg  <= err_count_next;
                        // the count never wraps back to zero, so zero means no mismatch yet
                        if (mismatch && (err_count_reg == 16'd0)) begin
                            first_err_idx_reg <= beat_count_reg;
                        end
                    end
                    if (last_beat) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                        pass_reg  <= (err_count_next == 16'd0);
                        error_reg <= (err_count_next != 16'd0);
                    end else if (timeout_hit) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                        pass_reg  <= 1'b0;
                        error_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign stream.ready_o  = ready;
    assign done_o          = done_reg;
    assign pass_o          = pass_reg;
    assign error_o         = error_reg;
    assign err_count_o     = err_count_reg;
    assign first_err_idx_o = first_err_idx_reg;
    assign beat_count_o    = beat_count_reg;

endmodule

// File: tb/tb_stream_seq_checker.sv
// Directed bench for stream_seq_checker: each run pushes its expected result
// to a scoreboard that is popped when done_o rises.
module tb_stream_seq_checker;

    localparam int W  = 32;
    localparam int N  = 256;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        done, pass, error, timeout;
    logic [15:0] err_count, first_idx, beat_count;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        pass;
        logic        error;
        logic [15:0] errs;
        logic [15:0] first;
        logic [15:0] beats;
        logic        timeout;
    } exp_t;

    exp_t sb[$];

    stream_seq_checker_if #(.width_p(W)) sif ();

    stream_seq_checker #(
        .width_p   (W),
        .count_p   (N),
        .timeout_p (TO)
    ) dut (
        .clk_i           (clk),
        .reset_ni        (reset_n),
        .start_i         (start),
        .mode_i          (mode),
        .stream          (sif),
        .done_o          (done),
        .pass_o          (pass),
        .error_o         (error),
        .err_count_o     (err_count),
        .first_err_idx_o (first_idx),
        .beat_count_o    (beat_count),
        .timeout_o       (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t make_exp(input logic p, input logic e, input int errs,
                                      input int first, input int beats, input logic t);
        exp_t r;
        r.pass    = p;
        r.error   = e;
        r.errs    = 16'(errs);
        r.first   = 16'(first);
        r.beats   = 16'(beats);
        r.timeout = t;
        return r;
    endfunction

    task automatic check_all_zero(input string name);
        check({name, "/ready"},      32'(sif.ready_o), 32'd0);
        check({name, "/done"},       32'(done),        32'd0);
        check({name, "/pass"},       32'(pass),        32'd0);
        check({name, "/error"},      32'(error),       32'd0);
        check({name, "/timeout"},    32'(timeout),     32'd0);
        check({name, "/err_count"},  32'(err_count),   32'd0);
        check({name, "/first_idx"},  32'(first_idx),   32'd0);
        check({name, "/beat_count"}, 32'(beat_count),  32'd0);
    endtask

    // One run: start, feed the ascending sequence (with optional corrupted beats),
    // poke start and mode mid-run, then compare against the scoreboard on done.
    task automatic run_case(input string name, input logic [1:0] m, input int bad_a,
                            input int bad_b, input bit rand_valid, input bit expect_done,
                            input exp_t e, input int limit, output int cycles);
        int   beats;
        logic v;
        exp_t got;
        if (expect_done) sb.push_back(e);
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mode  = ~m;
        beats  = 0;
        cycles = 0;
        check({name, "/entry_done"}, 32'(done), 32'd0);
        while (done !== 1'b1 && cycles < limit) begin
            check({name, "/beat_count"}, 32'(beat_count), 32'(beats));
            if (m == 2'b01 && cycles < 8)
                check({name, "/alt_ready"}, 32'(sif.ready_o), 32'(cycles[0]));
            if (m == 2'b10 && cycles == 0)
                check({name, "/lfsr_ready0"}, 32'(sif.ready_o), 32'd1);
            v = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            start = (cycles == 3);
            sif.valid_i = v;
            sif.data_i  = (beats == bad_a) ? 32'hDEAD :
                          (beats == bad_b) ? 32'h0    : 32'(beats);
            if (v && sif.ready_o === 1'b1) beats++;
            @(negedge clk);
            cycles++;
        end
        start       = 1'b0;
        sif.valid_i = 1'b0;
        if (expect_done) begin
            check({name, "/done"}, 32'(done), 32'd1);
            if (sb.size() > 0) begin
                got = sb.pop_front();
                check({name, "/pass"},      32'(pass),       32'(got.pass));
                check({name, "/error"},     32'(error),      32'(got.error));
                check({name, "/err_count"}, 32'(err_count),  32'(got.errs));
                check({name, "/first_idx"}, 32'(first_idx),  32'(got.first));
                check({name, "/beats"},     32'(beat_count), 32'(got.beats));
                check({name, "/timeout"},   32'(timeout),    32'(got.timeout));
            end
            check({name, "/tb_beats"}, 32'(beat_count), 32'(beats));
            @(negedge clk);
            check({name, "/done_hold"}, 32'(done), 32'd1);
        end else begin
            check({name, "/no_done"}, 32'(done), 32'd0);
        end
        $display("run %s mode=%0d cycles=%0d beats=%0d done=%0b pass=%0b errs=%0d",
                 name, m, cycles, beats, done, pass, err_count);
    endtask

    initial begin
        int cyc;
        sif.valid_i = 1'b0;
        sif.data_i  = '0;

        #12;
        check_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        run_case("mode00", 2'b00, -1, -1, 1'b0, 1'b1,
                 make_exp(1'b1, 1'b0, 0, 0, N, 1'b0), 400, cyc);
        check("mode00/cycles", 32'(cyc), 32'd256);

        run_case("mode01", 2'b01, -1, -1, 1'b0, 1'b1,
                 make_exp(1'b1, 1'b0, 0, 0, N, 1'b0), 700, cyc);
        check("mode01/cycles", 32'(cyc), 32'd512);

        run_case("errors", 2'b00, 5, 9, 1'b0, 1'b1,
                 make_exp(1'b0, 1'b1, 2, 5, N, 1'b0), 400, cyc);
        check("errors/cycles", 32'(cyc), 32'd256);

        run_case("lfsr", 2'b10, -1, -1, 1'b1, 1'b1,
                 make_exp(1'b1, 1'b0, 0, 0, N, 1'b0), 8000, cyc);

        // abort a run with reset part-way through
        @(negedge clk);
        mode  = 2'b00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            sif.valid_i = 1'b1;
            sif.data_i  = 32'(i);
            @(negedge clk);
        end
        check("midrun/beat_count", 32'(beat_count), 32'd100);
        #2 reset_n = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        sif.valid_i = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        $display("run midrun_reset beats=100 outputs cleared");

        run_case("after_reset", 2'b00, -1, -1, 1'b0, 1'b1,
                 make_exp(1'b1, 1'b0, 0, 0, N, 1'b0), 400, cyc);
        check("after_reset/cycles", 32'(cyc), 32'd256);

`ifdef STREAM_SEQ_CHECKER_TIMEOUT_EN
        run_case("timeout", 2'b11, -1, -1, 1'b0, 1'b1,
                 make_exp(1'b0, 1'b1, 0, 0, 0, 1'b1), 40, cyc);
        check("timeout/cycles", 32'(cyc), 32'(TO));
`else
        run_case("stall", 2'b11, -1, -1, 1'b0, 1'b0,
                 make_exp(1'b0, 1'b0, 0, 0, 0, 1'b0), 200, cyc);
        check("stall/cycles", 32'(cyc), 32'd200);
`endif

        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_all_zero("final_reset");
        @(negedge clk);
        reset_n = 1'b1;
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
